stopwatch_ctrl: RTL and testbench

Control sequencer for the stopwatch counter datapath. Debounces the two front-panel buttons, runs the IDLE/RUN/LAP/PAUSE mode state machine, and derives the 1 Hz count-enable tick from the system clock. The BCD seconds/minutes counter and the seven-segment driver sit downstream and consume `tick`, `count_clr` and `display_hold`.

---
 rtl/stopwatch_pkg.sv | 11 +
 rtl/stopwatch_ctrl_debounce.sv | 53 +++++
 rtl/stopwatch_ctrl.sv | 118 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared mode encoding for the stopwatch control sequencer.
package stopwatch_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'b00;
    localparam logic [STATE_W-1:0] ST_RUN   = 2'b01;
    localparam logic [STATE_W-1:0] ST_PAUSE = 2'b10;
    localparam logic [STATE_W-1:0] ST_LAP   = 2'b11;

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, accepted level
// and a one-cycle pulse on each accepted rising level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic CLK,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;

    // Bring the raw button into the CLK domain.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], btn_raw};
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_press <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign btn_level = r_level;
    assign btn_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode sequencer: debounced buttons, IDLE/RUN/LAP/PAUSE FSM and
// the TICK_HZ count-enable prescaler for the downstream BCD counter.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 100_000_000,
    parameter int unsigned TICK_HZ         = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               btn_start,
    input  logic               btn_lap,
    output logic               tick,
    output logic               count_clr,
    output logic               display_hold,
    output logic [STATE_W-1:0] state,
    output logic               running
);

    // DIV must be at least 2 so the prescaler has a real terminal count.
    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned PRE_W = $clog2(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic               w_start_press, w_start_level;
    logic               w_lap_press, w_lap_level;
    logic               w_start, w_lap;
    logic               w_cur_run;
    logic [STATE_W-1:0] w_next_state;
    logic               w_tick, w_count_clr, w_display_hold, w_running;

    logic [STATE_W-1:0] r_state;
    logic [PRE_W-1:0]   r_pre;
    logic               r_tick, r_count_clr, r_display_hold, r_running;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
        .CLK       (CLK),
        .reset     (reset),
        .btn_raw   (btn_start),
        .btn_level (w_start_level),
        .btn_press (w_start_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap_db (
        .CLK       (CLK),
        .reset     (reset),
        .btn_raw   (btn_lap),
        .btn_level (w_lap_level),
        .btn_press (w_lap_press)
    );

    // A press only counts while its accepted level is high; start wins over lap.
    assign w_start   = w_start_press & w_start_level;
    assign w_lap     = w_lap_press & w_lap_level & ~w_start;
    assign w_cur_run = (r_state == ST_RUN) || (r_state == ST_LAP);

    // State register plus registered copies of the outputs.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_tick         <= 1'b0;
            r_count_clr    <= 1'b0;
            r_display_hold <= 1'b0;
            r_running      <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_tick         <= w_tick;
            r_count_clr    <= w_count_clr;
            r_display_hold <= w_display_hold;
            r_running      <= w_running;
        end
    end

    // Mode transitions on debounced presses.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_next_state = ST_RUN;
            ST_RUN:   if (w_start) w_next_state = ST_PAUSE;
                      else if (w_lap) w_next_state = ST_LAP;
            ST_LAP:   if (w_start) w_next_state = ST_PAUSE;
                      else if (w_lap) w_next_state = ST_RUN;
            ST_PAUSE: if (w_start) w_next_state = ST_RUN;
                      else if (w_lap) w_next_state = ST_IDLE;
        endcase
    end

    // Output decode: mode flags follow the next state, tick follows the current one.
    always_comb begin
        w_tick         = 1'b0;
        w_count_clr    = 1'b0;
        w_display_hold = 1'b0;
        w_running      = 1'b0;
        w_tick         = w_cur_run && (r_pre == PRE_LAST);
        w_count_clr    = (r_state != ST_IDLE) && (w_next_state == ST_IDLE);
        w_display_hold = (w_next_state == ST_LAP);
        w_running      = (w_next_state == ST_RUN) || (w_next_state == ST_LAP);
    end

    // Prescaler: counts while running, holds in PAUSE, cleared in IDLE.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
        end else if (r_state == ST_IDLE) begin
            r_pre <= '0;
        end else if (w_cur_run) begin
            r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + PRE_W'(1);
        end
    end

    assign tick         = r_tick;
    assign count_clr    = r_count_clr;
    assign display_hold = r_display_hold;
    assign state        = r_state;
    assign running      = r_running;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (DIV=10, DEBOUNCE_CYCLES=4).
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int DIV = 10;
    localparam int LAT = 7;   // raw level stable -> state register updated

    typedef struct {
        int         c;
        logic [1:0] s;
    } sev_t;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_lap = 1'b0;
    logic       tick, count_clr, display_hold, running;
    logic [1:0] state;

    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;
    int   t_next = 0;
    bit   mon_en = 1'b0;
    logic [1:0] prev_state = ST_IDLE;
    int   tq[$];
    sev_t sq[$];

    stopwatch_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .DEBOUNCE_CYCLES(4)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .btn_start    (btn_start),
        .btn_lap      (btn_lap),
        .tick         (tick),
        .count_clr    (count_clr),
        .display_hold (display_hold),
        .state        (state),
        .running      (running)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard: pop expected tick / state events as the DUT produces them.
    always @(negedge CLK) begin
        int   t;
        sev_t e;
        if (mon_en) begin
            while (tq.size() > 0 && tq[0] < cyc) begin
                n_run++; n_fail++;
                t = tq.pop_front();
                $display("FAIL tick_missing: no tick seen, required at cycle %0d", t);
            end
            if (tick) begin
                n_run++;
                if (tq.size() == 0 || tq[0] != cyc) begin
                    n_fail++;
                    $display("FAIL tick_unexpected: tick at cycle %0d, next required %0d",
                             cyc, (tq.size() > 0) ? tq[0] : -1);
                end else begin
                    t = tq.pop_front();
                end
            end
            while (sq.size() > 0 && sq[0].c < cyc) begin
                n_run++; n_fail++;
                e = sq.pop_front();
                $display("FAIL state_missing: state %0d required at cycle %0d, state is %0d",
                         e.s, e.c, state);
            end
            if (state !== prev_state) begin
                n_run++;
                if (sq.size() == 0 || sq[0].c != cyc || sq[0].s !== state) begin
                    n_fail++;
                    $display("FAIL state_change: got %0d at cycle %0d, required %0d at cycle %0d",
                             state, cyc, (sq.size() > 0) ? int'(sq[0].s) : -1,
                             (sq.size() > 0) ? sq[0].c : -1);
                    if (sq.size() > 0 && sq[0].c == cyc) e = sq.pop_front();
                end else begin
                    e = sq.pop_front();
                end
            end
            n_run++;
            if ({display_hold, running, count_clr} !==
                {(state == ST_LAP), (state == ST_RUN || state == ST_LAP),
                 (state == ST_IDLE && prev_state == ST_PAUSE)}) begin
                n_fail++;
                $display("FAIL mode_flags: cycle %0d state %0d hold/run/clr=%b%b%b",
                         cyc, state, display_hold, running, count_clr);
            end
        end
        prev_state = state;
    end

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge CLK);
    endtask

    task automatic push_ticks(input int limit);
        while (t_next <= limit) begin
            tq.push_back(t_next);
            t_next += DIV;
        end
    endtask

    task automatic expect_state(input int c, input logic [1:0] s);
        sev_t e;
        e.c = c;
        e.s = s;
        sq.push_back(e);
    endtask

    task automatic test_reset();
        int nt;
        reset = 1'b1;
        repeat (3) @(negedge CLK);
        n_run++;
        if ({tick, count_clr, display_hold, state, running} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_values: got %b required 000000",
                     {tick, count_clr, display_hold, state, running});
        end
        reset = 1'b0;
        mon_en = 1'b1;
        nt = 0;
        repeat (50) begin
            @(negedge CLK);
            if (tick) nt++;
        end
        n_run++;
        if (nt !== 0 || state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_idle: ticks=%0d state=%0d required 0 and 0", nt, state);
        end
    endtask

    task automatic test_bounce();
        int c1, s;
        for (int i = 0; i < 6; i++) begin
            btn_start = (i % 2 == 0);
            repeat (2) @(negedge CLK);
        end
        btn_start = 1'b1;
        c1 = cyc;
        s = c1 + LAT;
        expect_state(s, ST_RUN);
        t_next = s + DIV;
        push_ticks(s + 3 * DIV);
        wait_until(c1 + 10);
        btn_start = 1'b0;
        wait_until(s + 3 * DIV + 1);
        n_run++;
        if (tq.size() != 0 || sq.size() != 0 || state !== ST_RUN) begin
            n_fail++;
            $display("FAIL bounce_end: pending ticks=%0d states=%0d state=%0d required 0 0 %0d",
                     tq.size(), sq.size(), state, ST_RUN);
        end
    endtask

    task automatic test_pause_resume();
        int tt, p, r;
        tt = t_next;
        push_ticks(tt);
        wait_until(tt - 4);
        p = cyc;
        btn_start = 1'b1;
        expect_state(p + LAT, ST_PAUSE);
        wait_until(p + 10);
        btn_start = 1'b0;
        wait_until(p + 50);
        n_run++;
        if (state !== ST_PAUSE || running !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_hold: state=%0d running=%b required %0d 0", state, running, ST_PAUSE);
        end
        wait_until(p + 100);
        btn_start = 1'b1;
        r = p + 100 + LAT;
        expect_state(r, ST_RUN);
        t_next = r + 7;
        push_ticks(r + 17);
        wait_until(p + 110);
        btn_start = 1'b0;
        wait_until(r + 18);
        n_run++;
        if (tq.size() != 0 || sq.size() != 0) begin
            n_fail++;
            $display("FAIL resume_end: pending ticks=%0d states=%0d required 0 0", tq.size(), sq.size());
        end
    endtask

    task automatic test_lap();
        int c, c2;
        c = cyc;
        push_ticks(c + 40);
        btn_lap = 1'b1;
        expect_state(c + LAT, ST_LAP);
        wait_until(c + 10);
        btn_lap = 1'b0;
        n_run++;
        if (display_hold !== 1'b1 || state !== ST_LAP) begin
            n_fail++;
            $display("FAIL lap_hold: hold=%b state=%0d required 1 %0d", display_hold, state, ST_LAP);
        end
        wait_until(c + 30);
        c2 = cyc;
        btn_lap = 1'b1;
        expect_state(c2 + LAT, ST_RUN);
        push_ticks(c2 + 20);
        wait_until(c2 + LAT + 1);
        n_run++;
        if (display_hold !== 1'b0 || state !== ST_RUN) begin
            n_fail++;
            $display("FAIL lap_release: hold=%b state=%0d required 0 %0d", display_hold, state, ST_RUN);
        end
        wait_until(c2 + 10);
        btn_lap = 1'b0;
        wait_until(c2 + 21);
        n_run++;
        if (tq.size() != 0 || sq.size() != 0) begin
            n_fail++;
            $display("FAIL lap_end: pending ticks=%0d states=%0d required 0 0", tq.size(), sq.size());
        end
    endtask

    task automatic test_clear();
        int c, c2, c3, s;
        c = cyc;
        push_ticks(c + LAT);
        btn_start = 1'b1;
        expect_state(c + LAT, ST_PAUSE);
        wait_until(c + 10);
        btn_start = 1'b0;
        wait_until(c + 20);
        c2 = cyc;
        btn_lap = 1'b1;
        expect_state(c2 + LAT, ST_IDLE);
        wait_until(c2 + LAT);
        n_run++;
        if (count_clr !== 1'b1 || state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL clear_pulse: count_clr=%b state=%0d required 1 0", count_clr, state);
        end
        wait_until(c2 + LAT + 1);
        n_run++;
        if (count_clr !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_width: count_clr=%b one cycle later, required 0", count_clr);
        end
        wait_until(c2 + 10);
        btn_lap = 1'b0;
        wait_until(c2 + 20);
        c3 = cyc;
        btn_start = 1'b1;
        s = c3 + LAT;
        expect_state(s, ST_RUN);
        t_next = s + DIV;
        push_ticks(s + 2 * DIV);
        wait_until(c3 + 10);
        btn_start = 1'b0;
        wait_until(s + 2 * DIV + 1);
        n_run++;
        if (tq.size() != 0 || sq.size() != 0) begin
            n_fail++;
            $display("FAIL clear_restart: pending ticks=%0d states=%0d required 0 0", tq.size(), sq.size());
        end
    endtask

    task automatic test_simultaneous();
        int c, c2, c3, c4;
        c = cyc;
        push_ticks(c + LAT);
        btn_start = 1'b1;
        btn_lap = 1'b1;
        expect_state(c + LAT, ST_PAUSE);
        wait_until(c + LAT + 1);
        n_run++;
        if (state !== ST_PAUSE || display_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_run: state=%0d hold=%b required %0d 0", state, display_hold, ST_PAUSE);
        end
        wait_until(c + 10);
        btn_start = 1'b0;
        btn_lap = 1'b0;
        wait_until(c + 20);
        c2 = cyc;
        btn_lap = 1'b1;
        expect_state(c2 + LAT, ST_IDLE);
        wait_until(c2 + 10);
        btn_lap = 1'b0;
        wait_until(c2 + 20);
        c3 = cyc;
        btn_lap = 1'b1;
        wait_until(c3 + 10);
        btn_lap = 1'b0;
        wait_until(c3 + 20);
        n_run++;
        if (state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL idle_lap: state=%0d required %0d", state, ST_IDLE);
        end
        c4 = cyc;
        btn_start = 1'b1;
        btn_lap = 1'b1;
        expect_state(c4 + LAT, ST_RUN);
        t_next = c4 + LAT + DIV;
        push_ticks(c4 + LAT + 2 * DIV);
        wait_until(c4 + 10);
        btn_start = 1'b0;
        btn_lap = 1'b0;
        wait_until(c4 + LAT + 2 * DIV + 1);
        n_run++;
        if (tq.size() != 0 || sq.size() != 0 || state !== ST_RUN) begin
            n_fail++;
            $display("FAIL simul_idle: pending ticks=%0d states=%0d state=%0d required 0 0 %0d",
                     tq.size(), sq.size(), state, ST_RUN);
        end
    endtask

    task automatic test_reset_mid();
        int c, c4;
        c = cyc;
        push_ticks(c + 13);
        btn_lap = 1'b1;
        expect_state(c + LAT, ST_LAP);
        wait_until(c + 10);
        btn_lap = 1'b0;
        wait_until(c + 13);
        mon_en = 1'b0;
        @(posedge CLK);
        #2;
        reset = 1'b1;
        #1;
        n_run++;
        if ({tick, count_clr, display_hold, state, running} !== 6'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b required 000000",
                     {tick, count_clr, display_hold, state, running});
        end
        tq.delete();
        sq.delete();
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        mon_en = 1'b1;
        c4 = cyc;
        btn_start = 1'b1;
        expect_state(c4 + LAT, ST_RUN);
        t_next = c4 + LAT + DIV;
        push_ticks(c4 + LAT + 2 * DIV);
        wait_until(c4 + 10);
        btn_start = 1'b0;
        wait_until(c4 + LAT + 2 * DIV + 1);
        n_run++;
        if (tq.size() != 0 || sq.size() != 0) begin
            n_fail++;
            $display("FAIL reset_restart: pending ticks=%0d states=%0d required 0 0", tq.size(), sq.size());
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_pause_resume();
        test_lap();
        test_clear();
        test_simultaneous();
        test_reset_mid();
        repeat (2) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
